// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types: response codes and the master bridge state encoding.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } master_state_t;

endpackage

// File: rtl/axi4_lite_master_bridge.sv
// Single-outstanding bridge from a command/response stream to AXI4-Lite master channels.
// All AXI valids/readies decode straight from registered state, never from an incoming ready.
module axi4_lite_master_bridge
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE    = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDRESS_SIZE-1:0]   cmd_addr,
    input  logic [DATA_SIZE-1:0]      cmd_wdata,
    input  logic [DATA_SIZE/8-1:0]    cmd_wstrb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_SIZE-1:0]      rsp_rdata,
    output logic [1:0]                rsp_resp,
    output logic [ADDRESS_SIZE-1:0]   m_axi_awaddr,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,
    output logic [DATA_SIZE-1:0]      m_axi_wdata,
    output logic [DATA_SIZE/8-1:0]    m_axi_wstrb,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,
    output logic [ADDRESS_SIZE-1:0]   m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_SIZE-1:0]      m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    master_state_t               state_q, state_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic                        write_q, write_d;
    logic [ADDRESS_SIZE-1:0]     addr_q, addr_d;
    logic [DATA_SIZE-1:0]        wdata_q, wdata_d;
    logic [DATA_SIZE/8-1:0]      wstrb_q, wstrb_d;
    logic [DATA_SIZE-1:0]        rdata_q, rdata_d;
    resp_t                       resp_q, resp_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= OKAY;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    write_d   = cmd_write;
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                // AW and W complete independently, in either order or together
                aw_done_d = aw_done_q | m_axi_awready;
                w_done_d  = w_done_q | m_axi_wready;
                if (aw_done_d && w_done_d) begin
                    state_d = WRESP;
                end
            end
            WRESP: begin
                if (m_axi_bvalid) begin
                    resp_d  = resp_t'(m_axi_bresp);
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            READ: begin
                if (m_axi_arready) begin
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (m_axi_rvalid) begin
                    rdata_d = m_axi_rdata;
                    resp_d  = resp_t'(m_axi_rresp);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready     = (state_q == IDLE);
    assign m_axi_awvalid = (state_q == WRITE) && !aw_done_q;
    assign m_axi_wvalid  = (state_q == WRITE) && !w_done_q;
    assign m_axi_bready  = (state_q == WRESP);
    assign m_axi_arvalid = (state_q == READ);
    assign m_axi_rready  = (state_q == RDATA);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign rsp_valid     = (state_q == RESP);
    assign rsp_write     = write_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Directed bench: a small negedge-driven AXI4-Lite slave model plus per-feature check tasks.
module tb_axi4_lite_master_bridge;

    logic        aclk;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    int checks;
    int errors;

    // slave configuration, written only by the main initial block
    int          aw_delay;
    logic        b_hold;
    logic [1:0]  r_resp_cfg;

    // slave internal state
    logic [31:0] mem [16] = '{default: 32'h0};
    int          aw_cnt, b_count;
    logic        aw_hs, w_hs, ar_hs, b_hs, r_hs, got_aw, got_w;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    axi4_lite_master_bridge #(.ADDRESS_SIZE(32), .DATA_SIZE(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Slave: retire the handshakes of the last rising edge, then drive for the next one.
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
            m_axi_bvalid = 0; m_axi_rvalid = 0; m_axi_bresp = 0; m_axi_rresp = 0; m_axi_rdata = 0;
            aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; got_aw = 0; got_w = 0; aw_cnt = 0;
        end else begin
            if (b_hs) begin m_axi_bvalid = 0; b_count++; end
            if (r_hs) m_axi_rvalid = 0;
            if (ar_hs) begin
                m_axi_rvalid = 1;
                m_axi_rdata  = mem[cap_araddr[5:2]];
                m_axi_rresp  = r_resp_cfg;
            end
            if (aw_hs) got_aw = 1;
            if (w_hs) got_w = 1;
            if (got_aw && got_w && !b_hold && !m_axi_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (cap_wstrb[b]) mem[cap_awaddr[5:2]][8*b +: 8] = cap_wdata[8*b +: 8];
                m_axi_bvalid = 1;
                m_axi_bresp  = 2'b00;
                got_aw = 0;
                got_w  = 0;
            end
            m_axi_awready = m_axi_awvalid && (aw_cnt == aw_delay);
            if (m_axi_awvalid && !m_axi_awready) aw_cnt++;
            else aw_cnt = 0;
            m_axi_wready  = m_axi_wvalid;
            m_axi_arready = m_axi_arvalid;
            aw_hs = m_axi_awvalid && m_axi_awready;
            w_hs  = m_axi_wvalid && m_axi_wready;
            ar_hs = m_axi_arvalid && m_axi_arready;
            b_hs  = m_axi_bvalid && m_axi_bready;
            r_hs  = m_axi_rvalid && m_axi_rready;
            if (aw_hs) cap_awaddr = m_axi_awaddr;
            if (w_hs) begin cap_wdata = m_axi_wdata; cap_wstrb = m_axi_wstrb; end
            if (ar_hs) cap_araddr = m_axi_araddr;
        end
    end

    task automatic tick;
        @(negedge aclk);
        #1;
    endtask

    // Presents one command for a single cycle; returns in the cycle after acceptance.
    task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        tick();
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++; $display("FAIL cmd_ready_at_issue: got %b expected 1", cmd_ready);
        end
        tick();
        cmd_valid = 0;
        $display("transaction %s addr=%h wdata=%h wstrb=%b", w ? "write" : "read ", a, d, s);
    endtask

    task automatic consume_rsp(input string name);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after_rsp: got rsp_valid=%b cmd_ready=%b expected 0/1", name, rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL reset_valids: got %b expected 000000",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid});
        end
        checks++;
        if (cmd_ready !== 1'b1 || rsp_rdata !== 32'h0 || m_axi_awaddr !== 32'h0) begin
            errors++; $display("FAIL reset_regs: got cmd_ready=%b rdata=%h awaddr=%h expected 1/0/0",
                cmd_ready, rsp_rdata, m_axi_awaddr);
        end
        tick(); tick();
        aresetn = 1;
    endtask

    task automatic test_write;
        send_cmd(1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (m_axi_awvalid !== 1 || m_axi_wvalid !== 1 || m_axi_bready !== 0) begin
            errors++; $display("FAIL write_c1_valids: got aw=%b w=%b b=%b expected 1/1/0",
                m_axi_awvalid, m_axi_wvalid, m_axi_bready);
        end
        checks++;
        if (m_axi_awaddr !== 32'h4 || m_axi_wdata !== 32'hDEAD_BEEF || m_axi_wstrb !== 4'hF) begin
            errors++; $display("FAIL write_c1_payload: got %h %h %h expected 00000004 deadbeef f",
                m_axi_awaddr, m_axi_wdata, m_axi_wstrb);
        end
        tick();
        checks++;
        if (m_axi_bready !== 1 || m_axi_awvalid !== 0 || m_axi_wvalid !== 0 || rsp_valid !== 0) begin
            errors++; $display("FAIL write_c2: got bready=%b aw=%b w=%b rsp=%b expected 1/0/0/0",
                m_axi_bready, m_axi_awvalid, m_axi_wvalid, rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1 || rsp_write !== 1 || rsp_resp !== 2'b00 || rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL write_rsp: got v=%b w=%b resp=%b rdata=%h expected 1/1/00/0",
                rsp_valid, rsp_write, rsp_resp, rsp_rdata);
        end
        consume_rsp("write");
    endtask

    task automatic test_read;
        send_cmd(0, 32'h0000_0004, 32'h0, 4'h0);
        checks++;
        if (m_axi_arvalid !== 1 || m_axi_araddr !== 32'h4 || m_axi_rready !== 0) begin
            errors++; $display("FAIL read_c1: got ar=%b araddr=%h rready=%b expected 1/00000004/0",
                m_axi_arvalid, m_axi_araddr, m_axi_rready);
        end
        tick();
        checks++;
        if (m_axi_rready !== 1 || m_axi_arvalid !== 0) begin
            errors++; $display("FAIL read_c2: got rready=%b ar=%b expected 1/0", m_axi_rready, m_axi_arvalid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1 || rsp_write !== 0 || rsp_resp !== 2'b00 || rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL read_rsp: got v=%b w=%b resp=%b rdata=%h expected 1/0/00/deadbeef",
                rsp_valid, rsp_write, rsp_resp, rsp_rdata);
        end
        consume_rsp("read");
    endtask

    task automatic test_aw_stall;
        int prev_b;
        int n;
        prev_b   = b_count;
        aw_delay = 4;
        send_cmd(1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (m_axi_awvalid !== 1 || m_axi_awaddr !== 32'h10 || m_axi_wvalid !== (i == 1)) begin
                errors++; $display("FAIL aw_stall_cycle%0d: got aw=%b awaddr=%h w=%b expected 1/00000010/%b",
                    i, m_axi_awvalid, m_axi_awaddr, m_axi_wvalid, (i == 1));
            end
            tick();
        end
        checks++;
        if (m_axi_awvalid !== 0 || m_axi_bready !== 1) begin
            errors++; $display("FAIL aw_stall_done: got aw=%b bready=%b expected 0/1", m_axi_awvalid, m_axi_bready);
        end
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        checks++;
        if (rsp_valid !== 1 || n != 1 || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL aw_stall_rsp: got v=%b wait=%0d resp=%b expected 1/1/00", rsp_valid, n, rsp_resp);
        end
        consume_rsp("aw_stall");
        aw_delay = 0;
        checks++;
        if (b_count != prev_b + 1) begin
            errors++; $display("FAIL aw_stall_bcount: got %0d expected %0d", b_count - prev_b, 1);
        end
        tick(); tick();
        checks++;
        if (rsp_valid !== 0) begin
            errors++; $display("FAIL aw_stall_single_rsp: got rsp_valid=%b expected 0", rsp_valid);
        end
    endtask

    task automatic test_read_error;
        r_resp_cfg = 2'b10;
        send_cmd(0, 32'h0000_0008, 32'h0, 4'h0);
        tick(); tick();
        checks++;
        if (rsp_valid !== 1 || rsp_resp !== 2'b10) begin
            errors++; $display("FAIL rderr_rsp: got v=%b resp=%b expected 1/10", rsp_valid, rsp_resp);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rsp_valid !== 1 || rsp_resp !== 2'b10 || rsp_write !== 0 || cmd_ready !== 0) begin
                errors++; $display("FAIL rderr_hold%0d: got v=%b resp=%b w=%b cmd_ready=%b expected 1/10/0/0",
                    i, rsp_valid, rsp_resp, rsp_write, cmd_ready);
            end
        end
        rsp_ready = 1;
        checks++;
        if (cmd_ready !== 0) begin
            errors++; $display("FAIL rderr_same_cycle_ready: got cmd_ready=%b expected 0", cmd_ready);
        end
        tick();
        rsp_ready = 0;
        checks++;
        if (cmd_ready !== 1 || rsp_valid !== 0) begin
            errors++; $display("FAIL rderr_release: got cmd_ready=%b v=%b expected 1/0", cmd_ready, rsp_valid);
        end
        r_resp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid;
        b_hold = 1;
        send_cmd(1, 32'h0000_0020, 32'h1234_5678, 4'hF);
        tick();
        checks++;
        if (m_axi_bready !== 1) begin
            errors++; $display("FAIL midrst_in_wresp: got bready=%b expected 1", m_axi_bready);
        end
        #2 aresetn = 0;
        #1;
        checks++;
        if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid} !== 6'b0
            || cmd_ready !== 1) begin
            errors++; $display("FAIL midrst_async: got valids=%b cmd_ready=%b expected 000000/1",
                {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid}, cmd_ready);
        end
        tick();
        b_hold  = 0;
        aresetn = 1;
        send_cmd(0, 32'h0000_0004, 32'h0, 4'h0);
        tick(); tick();
        checks++;
        if (rsp_valid !== 1 || rsp_rdata !== 32'hDEAD_BEEF || rsp_resp !== 2'b00) begin
            errors++; $display("FAIL midrst_next_cmd: got v=%b rdata=%h resp=%b expected 1/deadbeef/00",
                rsp_valid, rsp_rdata, rsp_resp);
        end
        consume_rsp("midrst");
    endtask

    task automatic test_strobe;
        send_cmd(1, 32'h0000_000C, 32'h1122_3344, 4'b0010);
        checks++;
        if (m_axi_wvalid !== 1 || m_axi_wready !== 1 || m_axi_wstrb !== 4'b0010) begin
            errors++; $display("FAIL strobe_w_hs: got wvalid=%b wready=%b wstrb=%b expected 1/1/0010",
                m_axi_wvalid, m_axi_wready, m_axi_wstrb);
        end
        tick(); tick();
        checks++;
        if (rsp_valid !== 1 || rsp_resp !== 2'b00 || rsp_write !== 1) begin
            errors++; $display("FAIL strobe_rsp: got v=%b resp=%b w=%b expected 1/00/1", rsp_valid, rsp_resp, rsp_write);
        end
        consume_rsp("strobe_wr");
        send_cmd(0, 32'h0000_000C, 32'h0, 4'h0);
        tick(); tick();
        checks++;
        if (rsp_valid !== 1 || rsp_rdata !== 32'h0000_3300) begin
            errors++; $display("FAIL strobe_readback: got v=%b rdata=%h expected 1/00003300", rsp_valid, rsp_rdata);
        end
        consume_rsp("strobe_rd");
    endtask

    initial begin
        checks = 0; errors = 0; b_count = 0;
        aw_delay = 0; b_hold = 0; r_resp_cfg = 2'b00;
        aresetn = 0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        test_reset();
        test_write();
        test_read();
        test_aw_stall();
        test_read_error();
        test_reset_mid();
        test_strobe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master_bridge.md
Name: axi4_lite_master_bridge

Overview:
- Converts a simple single-beat command/response stream into AXI4-Lite master transactions.
- Sits directly upstream of the team's AXI4-Lite register slave and drives its AW/W/B/AR/R channels.
- Lets sequencers, test logic and soft controllers read and write slave registers without handling the five AXI channels.
- One transaction outstanding at a time. No reordering, no bursts.

Parameters:
- ADDRESS_SIZE, 32, width of command address and m_axi_awaddr/m_axi_araddr.
- DATA_SIZE, 32, data width; must be a multiple of 8; strobe width is DATA_SIZE/8.

Ports:
- aclk  in  1  clock; everything is sampled on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRESS_SIZE  target address, passed unchanged to AXI.
- cmd_wdata  in  DATA_SIZE  write data (ignored for reads).
- cmd_wstrb  in  DATA_SIZE/8  byte enables (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of cmd_write for this response.
- rsp_rdata  out  DATA_SIZE  read data; 0 for writes.
- rsp_resp  out  2  AXI BRESP/RRESP of the transaction.
- m_axi_awaddr / m_axi_awvalid / m_axi_awready  out / out / in  ADDRESS_SIZE / 1 / 1  write address channel.
- m_axi_wdata / m_axi_wstrb / m_axi_wvalid / m_axi_wready  out / out / out / in  DATA_SIZE / DATA_SIZE/8 / 1 / 1  write data channel.
- m_axi_bresp / m_axi_bvalid / m_axi_bready  in / in / out  2 / 1 / 1  write response channel.
- m_axi_araddr / m_axi_arvalid / m_axi_arready  out / out / in  ADDRESS_SIZE / 1 / 1  read address channel.
- m_axi_rdata / m_axi_rresp / m_axi_rvalid / m_axi_rready  in / in / in / out  DATA_SIZE / 2 / 1 / 1  read data channel.

Behaviour:
- Clock and reset: one clock, aclk. aresetn is asynchronous and active-low.
- Reset values: state IDLE; all AXI valids, bready, rready and rsp_valid are 0; addr/data/strb/rsp registers are 0.
- cmd_ready = (state == IDLE) is combinational, so it reads 1 during reset.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, RESP.
- IDLE:
  - On accept, latch addr/wdata/wstrb/write.
  - Write: go to WRITE, assert awvalid and wvalid on the next cycle.
  - Read: go to READ, assert arvalid on the next cycle.
  - Earliest AXI valid is 1 cycle after command accept.
- WRITE:
  - AW and W are tracked by independent done flags.
  - Each valid drops the cycle after its own handshake.
  - Both handshakes may complete in the same cycle or in either order.
  - When both are done, go to WRESP.
- WRESP: bready = 1. On bvalid, capture bresp, set rsp_rdata = 0, go to RESP.
- READ: hold arvalid until arready, then go to RDATA.
- RDATA: rready = 1. On rvalid, capture rdata/rresp, go to RESP.
- RESP:
  - rsp_valid = 1, rsp_* held stable until rsp_ready.
  - On rsp_ready, return to IDLE; cmd_ready is high the following cycle (no back-to-back accept in the same cycle as the response).
- AXI rules:
  - A valid never depends combinationally on the matching ready.
  - Once asserted, a valid and its payload stay stable until the handshake.
  - bready and rready are registered: high only in WRESP/RDATA.
- Minimum latencies with zero-wait slave ready and immediate responses:
  - Write: accept to rsp_valid = 3 cycles.
  - Read: accept to rsp_valid = 3 cycles.
- Error responses: SLVERR/DECERR are passed through unmodified. No retry.
- Unexpected traffic: bvalid/rvalid in any state other than WRESP/RDATA is ignored, and its ready stays 0.
- Reset mid-transaction: immediate return to IDLE, all valids drop. The in-flight transaction is abandoned and the slave is required to be reset with it.
- Strobe: cmd_wstrb is forwarded as-is. All-zero strobe is legal and still issues AW/W.

Decomposition:
- Package axi4_lite_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - master_state_t enum for the six states.
  - The slave side reuses resp_t.
- No sub-module is required; the FSM and channel registers live in one module.

Test Plan:
- Write 0x0000_0004 / 0xDEAD_BEEF / strb 4'hF with an always-ready slave -> AW and W valid together 1 cycle after accept; bready 1 cycle later; rsp_valid 3 cycles after accept with rsp_write=1, rsp_resp=2'b00, rsp_rdata=0.
- Read 0x0000_0004 after the previous write, slave returns the stored value -> rsp_rdata=0xDEAD_BEEF, rsp_resp=OKAY, rsp_write=0, latency 3 cycles.
- Slave holds awready low 4 cycles while wready is immediate -> wvalid drops after 1 cycle; awvalid and awaddr stay stable for 5 cycles; a single B is consumed; one response is produced.
- Slave returns rresp=2'b10 with rsp_ready held low 3 cycles -> rsp_valid stays high with rsp_resp=SLVERR stable; cmd_ready stays 0 until the cycle after rsp_ready.
- aresetn pulsed low while in WRESP -> all AXI valids, bready and rsp_valid go 0 asynchronously; cmd_ready=1; the next command completes normally.
- Write with cmd_wstrb=4'b0010 -> m_axi_wstrb=4'b0010 observed at the W handshake; rsp_resp=OKAY.
